bank_read_sequencer: RTL and testbench
======================================

// Module: bank_read_sequencer
// PURPOSE
//  Read-side controller for memoryBank. On a start pulse it generates skewed per-column read locations.
//  It captures the bank's outputElementVector and presents a diagonally staggered, zero-padded feed vector to the systolic array.
//  It sits between memoryBank (read ports) and the array's input edge, and pairs with the bank write path.
// PARAMETERS
//  matrixSize   4   columns in the bank / rows per column; N below
//  dataSize     16  signed element width
//  readLatency  1   cycles from readLocationVector to valid bankDataVector (>=0)
// PORTS
//  clk                 in   1                  sole clock, rising edge
//  rst                 in   1                  synchronous, active-high reset
//  start               in   1                  pulse; begin one N x N read pass
//  busy                out  1                  pass in progress (STREAM or DRAIN)
//  done                out  1                  one-cycle pulse with final feed element
//  readLocationVector  out  [N][clog2(N)]      to memoryBank readLocationVector
//  bankDataVector      in   [N][dataSize] s    from memoryBank outputElementVector
//  feedVector          out  [N][dataSize] s    skewed data to array; 0 when lane inactive
//  feedValid           out  [N]                per-lane valid, aligned with feedVector
// BEHAVIOUR
//  Reset: state=IDLE, t=0; busy=0, done=0, all readLocationVector=0, feedVector=0, feedValid=0, delay line cleared.
//  rst mid-pass aborts immediately; no done is produced. The first cycle after reset behaves as IDLE.
//  FSM: IDLE -> STREAM -> DRAIN -> IDLE.
//   IDLE: start=1 sampled -> STREAM with t=0 next cycle. start=0 -> stay.
//   STREAM: t counts 0..2N-2, one step per cycle. At t=2N-2 -> DRAIN if readLatency>0, else -> IDLE.
//   DRAIN: counts readLatency cycles, then -> IDLE.
//   start while busy is ignored (no queueing, no restart).
//  Counter width is clog2(2N) bits. No wrap is possible; t never exceeds 2N-2.
//  Lane i is active at step t iff i <= t <= i+N-1.
//   Active lane: readLocationVector[i] = t-i, truncated to clog2(N) bits.
//   Inactive lane: readLocationVector[i] = 0.
//  readLocationVector and laneActive are registered. They are valid in the cycle where the FSM holds step t.
//  laneActive[i] is delayed by readLatency cycles to give feedValid[i].
//  feedVector[i] = feedValid[i] ? bankDataVector[i] : 0. This path is combinational from bankDataVector, with no extra register.
//  Alignment: the feed for step t appears readLatency cycles after that step's address.
//  busy=1 in every STREAM and DRAIN cycle.
//  done=1 exactly in the cycle feedValid[N-1] is high for step 2N-2, i.e. the last element (lane N-1, row N-1).
//   That cycle is 2N-1+readLatency cycles after start is sampled.
//  Back-to-back passes: start may be sampled in the first IDLE cycle after the pass. There is no idle gap beyond that.
//  The bank write path is not interlocked here. Writes during a pass are a system-level error and give undefined feed data.
//  Data is passed through unmodified. No arithmetic on data; sign is preserved.
// STRUCTURE
//  tpu_pkg:
//   - typedef seq_state_t {IDLE, STREAM, DRAIN}
//   - function/localparam for locWidth = $clog2(matrixSize) and stepWidth = $clog2(2*matrixSize)
//  Sub-module valid_delay_line:
//   - parameters width N and depth readLatency
//   - sync reset to 0; depth 0 is a wire
//   - carries laneActive to feedValid
//  The top module holds the FSM, step counter, address generation and output mux.
// TESTING
//  1. N=4, L=1: start pulse at cycle 0.
//     -> busy high cycles 1..8.
//     -> readLocationVector at t=0 is {0,0,0,0} with only lane0 active; at t=3 it is {3,2,1,0}; at t=6 lane3=3 only.
//     -> done at cycle 8.
//  2. Bank column i loaded with values 10*i+r.
//     -> feedVector lane2 emits 20,21,22,23 at t=2..5 (+L).
//     -> zeros elsewhere; feedValid matches.
//  3. start held high for 12 cycles.
//     -> exactly one pass, then a second pass beginning the first cycle after done.
//     -> no start captured mid-pass.
//  4. rst asserted at t=3.
//     -> next cycle all outputs 0, busy=0; done never pulses.
//     -> a new start then gives a clean full pass.
//  5. readLatency=0 and readLatency=3.
//     -> done at cycle 2N-1+L (7 and 10 for N=4).
//     -> feedValid is the laneActive pattern shifted by L.
//  6. Negative data (-32768, -1) in lane 0.
//     -> feedVector reproduces the values bit-exact; inactive lanes stay 0 throughout.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and width helpers for the bank read sequencer.
// Width helpers are functions because they depend on the instantiating module's matrixSize.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } seq_state_t;

  // Address width for one bank column; a single-row bank still needs one bit.
  function automatic int loc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Step counter width; must hold the last step, 2N-2.
  function automatic int step_width(input int n);
    return (n > 1) ? $clog2(2 * n) : 1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that carries per-lane activity flags alongside the bank read latency.
// When DEPTH is 0 the input passes straight through as a wire.
module valid_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_pipe[k] <= '0;
          end
        end else begin
          r_pipe[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) begin
            r_pipe[k] <= r_pipe[k-1];
          end
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/bank_read_sequencer.sv
// Read-side controller for memoryBank: walks 2N-1 skewed steps, issues per-column read
// locations and forwards the returned bank data as a diagonally staggered feed vector.
module bank_read_sequencer
  import tpu_pkg::*;
#(
  parameter int matrixSize  = 4,
  parameter int dataSize    = 16,
  parameter int readLatency = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  output logic                                               busy,
  output logic                                               done,
  output logic [matrixSize-1:0][loc_width(matrixSize)-1:0]   readLocationVector,
  input  logic [matrixSize-1:0][dataSize-1:0]                bankDataVector,
  output logic [matrixSize-1:0][dataSize-1:0]                feedVector,
  output logic [matrixSize-1:0]                              feedValid,
  output seq_state_t                                         o_dbg_state
);

  localparam int N  = matrixSize;
  localparam int LW = loc_width(matrixSize);
  localparam int SW = step_width(matrixSize);
  localparam int DW = (readLatency > 1) ? $clog2(readLatency) : 1;
  localparam logic [SW-1:0] LAST_T = SW'(2 * N - 2);

  seq_state_t            r_state;
  seq_state_t            w_next_state;
  logic [SW-1:0]         r_t;
  logic [SW-1:0]         w_next_t;
  logic [DW-1:0]         r_drain;
  logic [DW-1:0]         w_next_drain;

  logic [N-1:0][LW-1:0]  r_loc;
  logic [N-1:0][LW-1:0]  w_next_loc;
  logic [N-1:0]          r_active;
  logic [N-1:0]          w_next_active;
  logic                  r_last;
  logic                  w_next_last;

  logic [N:0]            w_delayed;

  // State register: FSM state, step counter and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next_state;
      r_t     <= w_next_t;
      r_drain <= w_next_drain;
    end
  end

  // Next-state logic. start is only honoured in IDLE, so a held start cannot restart a pass.
  always_comb begin
    w_next_state = r_state;
    w_next_t     = r_t;
    w_next_drain = r_drain;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = STREAM;
          w_next_t     = '0;
        end
      end
      STREAM: begin
        if (r_t == LAST_T) begin
          w_next_drain = '0;
          w_next_state = (readLatency > 0) ? DRAIN : IDLE;
        end else begin
          w_next_t = r_t + 1'b1;
        end
      end
      DRAIN: begin
        if (int'(r_drain) >= readLatency - 1) begin
          w_next_state = IDLE;
        end else begin
          w_next_drain = r_drain + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output logic. Addresses are computed from the next step so the registered copy lines up
  // with the cycle in which the FSM holds that step.
  always_comb begin
    busy        = (r_state != IDLE);
    o_dbg_state = r_state;
    w_next_last = (w_next_state == STREAM) && (w_next_t == LAST_T);
    for (int i = 0; i < N; i++) begin
      w_next_active[i] = (w_next_state == STREAM) &&
                         (int'(w_next_t) >= i) &&
                         (int'(w_next_t) <= i + N - 1);
      w_next_loc[i]    = w_next_active[i] ? LW'(int'(w_next_t) - i) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loc    <= '0;
      r_active <= '0;
      r_last   <= 1'b0;
    end else begin
      r_loc    <= w_next_loc;
      r_active <= w_next_active;
      r_last   <= w_next_last;
    end
  end

  assign readLocationVector = r_loc;

  // The last-step marker rides the same delay as the lane flags, so done lands on the final element.
  valid_delay_line #(
    .WIDTH (N + 1),
    .DEPTH (readLatency)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .i_d ({r_last, r_active}),
    .o_q (w_delayed)
  );

  assign feedValid = w_delayed[N-1:0];
  assign done      = w_delayed[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      feedVector[i] = feedValid[i] ? bankDataVector[i] : '0;
    end
  end

endmodule

// File: tb/tb_bank_read_sequencer.sv
// Bench for bank_read_sequencer: three instances (read latency 0, 1, 3) share stimulus and a
// behavioural memoryBank model; a pass-level reference predicts every output each cycle.
module tb_bank_read_sequencer;
  import tpu_pkg::*;

  localparam int N    = 4;
  localparam int DWID = 16;
  localparam int NONE = -100000;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [DWID-1:0] mem [N][N];

  logic                        busy0, busy1, busy3, done0, done1, done3;
  logic [N-1:0][1:0]           loc0, loc1, loc3;
  logic [N-1:0][DWID-1:0]      bank0, bank1, bank3;
  logic [N-1:0][DWID-1:0]      feed0, feed1, feed3;
  logic [N-1:0]                fv0, fv1, fv3;
  seq_state_t                  st0, st1, st3;
  logic [N-1:0][DWID-1:0]      p3a, p3b;

  bank_read_sequencer #(.matrixSize(N), .dataSize(DWID), .readLatency(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .readLocationVector(loc0), .bankDataVector(bank0), .feedVector(feed0),
    .feedValid(fv0), .o_dbg_state(st0));

  bank_read_sequencer #(.matrixSize(N), .dataSize(DWID), .readLatency(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .readLocationVector(loc1), .bankDataVector(bank1), .feedVector(feed1),
    .feedValid(fv1), .o_dbg_state(st1));

  bank_read_sequencer #(.matrixSize(N), .dataSize(DWID), .readLatency(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy3), .done(done3),
    .readLocationVector(loc3), .bankDataVector(bank3), .feedVector(feed3),
    .feedValid(fv3), .o_dbg_state(st3));

  // memoryBank model: column i is addressed by readLocationVector[i], data after the latency.
  always_comb begin
    for (int i = 0; i < N; i++) bank0[i] = mem[i][loc0[i]];
  end

  initial begin
    bank1 = '0; bank3 = '0; p3a = '0; p3b = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bank1[i] <= mem[i][loc1[i]];
      p3a[i]   <= mem[i][loc3[i]];
    end
    p3b   <= p3a;
    bank3 <= p3b;
  end

  // reference model and scoreboard state
  int lat [3] = '{0, 1, 3};
  int c0  [3] = '{NONE, NONE, NONE};
  int n = 0;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic bit model_busy(input int j, input int cyc);
    int k;
    k = cyc - c0[j];
    return (k >= 1) && (k <= 2 * N - 1 + lat[j]);
  endfunction

  task automatic check_dut(input int j, input logic b, input logic d,
                           input logic [N-1:0][1:0] loc, input logic [N-1:0][DWID-1:0] fd,
                           input logic [N-1:0] fv, input seq_state_t st);
    int k, t, s, lt;
    logic eb, ed;
    logic [N-1:0][1:0]      el;
    logic [N-1:0][DWID-1:0] ef;
    logic [N-1:0]           ev;
    lt = lat[j];
    k  = n - c0[j];
    t  = k - 1;
    s  = k - 1 - lt;
    eb = model_busy(j, n);
    ed = (s == 2 * N - 2);
    for (int i = 0; i < N; i++) begin
      el[i] = (t >= i && t <= i + N - 1) ? 2'(t - i) : 2'd0;
      ev[i] = (s >= i && s <= i + N - 1);
      ef[i] = ev[i] ? mem[i][s - i] : '0;
    end
    n_assert++;
    assert (b === eb) else begin
      n_fail++; $error("FAIL busy_L%0d cyc=%0d obs=%b exp=%b", lt, n, b, eb);
    end
    n_assert++;
    assert ((st != IDLE) === eb) else begin
      n_fail++; $error("FAIL state_L%0d cyc=%0d obs=%0d exp_busy=%b", lt, n, st, eb);
    end
    n_assert++;
    assert (d === ed) else begin
      n_fail++; $error("FAIL done_L%0d cyc=%0d obs=%b exp=%b", lt, n, d, ed);
    end
    n_assert++;
    assert (loc === el) else begin
      n_fail++; $error("FAIL loc_L%0d cyc=%0d obs=%h exp=%h", lt, n, loc, el);
    end
    n_assert++;
    assert (fv === ev) else begin
      n_fail++; $error("FAIL feedValid_L%0d cyc=%0d obs=%b exp=%b", lt, n, fv, ev);
    end
    n_assert++;
    assert (fd === ef) else begin
      n_fail++; $error("FAIL feed_L%0d cyc=%0d obs=%h exp=%h", lt, n, fd, ef);
    end
  endtask

  // driver: check the current cycle, then drive inputs sampled at the next rising edge
  task automatic step(input logic st, input logic rs);
    @(negedge clk);
    check_dut(0, busy0, done0, loc0, feed0, fv0, st0);
    check_dut(1, busy1, done1, loc1, feed1, fv1, st1);
    check_dut(2, busy3, done3, loc3, feed3, fv3, st3);
    start = st;
    rst   = rs;
    for (int j = 0; j < 3; j++) begin
      if (rs) c0[j] = NONE;
      else if (st && !model_busy(j, n)) c0[j] = n;
    end
    n++;
  endtask

  task automatic idle_steps(input int cnt);
    for (int q = 0; q < cnt; q++) step(1'b0, 1'b0);
  endtask

  function automatic bit all_idle();
    return !model_busy(0, n) && !model_busy(1, n) && !model_busy(2, n);
  endfunction

  initial begin
    for (int i = 0; i < N; i++)
      for (int r = 0; r < N; r++) mem[i][r] = DWID'(10 * i + r);

    // reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle_steps(2);

    // single pass over the 10*i+r pattern
    step(1'b1, 1'b0);
    idle_steps(12);

    // random contents, second pass
    for (int i = 0; i < N; i++)
      for (int r = 0; r < N; r++) mem[i][r] = DWID'($urandom);
    step(1'b1, 1'b0);
    idle_steps(12);

    // start held high: back-to-back passes, nothing captured mid-pass
    for (int q = 0; q < 24; q++) step(1'b1, 1'b0);
    idle_steps(12);

    // reset at step t=3, then a clean pass
    step(1'b1, 1'b0);
    idle_steps(3);
    step(1'b0, 1'b1);
    idle_steps(3);
    step(1'b1, 1'b0);
    idle_steps(12);

    // negative extremes in lane 0
    mem[0][0] = 16'h8000;
    mem[0][1] = 16'hffff;
    mem[0][2] = 16'h8000;
    mem[0][3] = 16'hffff;
    step(1'b1, 1'b0);
    idle_steps(12);

    // random start/reset traffic; bank contents change only between passes
    for (int q = 0; q < 200; q++) begin
      if (all_idle() && $urandom_range(3) == 0)
        mem[$urandom_range(N - 1)][$urandom_range(N - 1)] = DWID'($urandom);
      step(($urandom_range(3) == 0), ($urandom_range(39) == 0));
    end
    idle_steps(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
